// File: rtl/jtcps1_obj_scan.sv
// jtcps1_obj_scan: walks the OBJ table for one scanline, emitting one draw request per intersecting tile.
module jtcps1_obj_scan #(
  parameter int LAST_OBJ = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  vrender,
  output logic [9:0]  table_addr,
  input  logic [15:0] table_data,
  output logic        dr_valid,
  input  logic        dr_ready,
  output logic [15:0] dr_code,
  output logic [8:0]  dr_hpos,
  output logic [3:0]  dr_vsub,
  output logic [4:0]  dr_pal,
  output logic        dr_hflip,
  output logic        busy,
  output logic        line_done
);
  typedef enum logic [3:0] {
    S_IDLE, S_RD_ATTR, S_RD_Y, S_RD_X, S_RD_CODE, S_CHECK, S_EMIT, S_NEXT, S_END
  } state_t;
  state_t      state_q, state_d;
  logic [7:0]  obj_q, obj_d;
  logic [8:0]  vline_q, vline_d, y_q, y_d, x_q, x_d;
  logic [15:0] code_q, code_d;
  logic [3:0]  w_q, w_d, h_q, h_d, ny_q, ny_d, vsub_q, vsub_d, c_q, c_d;
  logic        vflip_q, vflip_d, hflip_q, hflip_d, dr_valid_q, dr_valid_d;
  logic [4:0]  pal_q, pal_d;
  logic [8:0]  diff;
  logic [3:0]  nx, lo;
  logic        hit;
  assign diff       = vline_q - y_q;
  assign hit        = diff[8:4] <= {1'b0, h_q};
  assign nx         = hflip_q ? w_q - c_q : c_q;
  assign lo         = code_q[3:0] + nx;
  // Column offset wraps inside the low nibble; the row offset carries into the upper code bits.
  assign dr_code    = {code_q[15:4], 4'h0} + {12'h0, lo} + {8'h0, ny_q, 4'h0};
  assign dr_hpos    = x_q + {1'b0, c_q, 4'h0};
  assign dr_vsub    = vsub_q;
  assign dr_pal     = pal_q;
  assign dr_hflip   = hflip_q;
  assign dr_valid   = dr_valid_q;
  assign busy       = state_q != S_IDLE;
  assign line_done  = state_q == S_END;
  assign table_addr = state_q == S_RD_ATTR ? {obj_q, 2'd3} :
                      state_q == S_RD_Y    ? {obj_q, 2'd1} :
                      state_q == S_RD_X    ? {obj_q, 2'd0} :
                      state_q == S_RD_CODE ? {obj_q, 2'd2} : 10'd0;
  always_comb begin
    state_d    = state_q;
    obj_d      = obj_q;
    vline_d    = vline_q;
    y_d        = y_q;
    x_d        = x_q;
    code_d     = code_q;
    w_d        = w_q;
    h_d        = h_q;
    ny_d       = ny_q;
    vsub_d     = vsub_q;
    c_d        = c_q;
    vflip_d    = vflip_q;
    hflip_d    = hflip_q;
    pal_d      = pal_q;
    dr_valid_d = dr_valid_q;
    // Each state captures the word addressed by the previous state.
    case (state_q)
      S_RD_ATTR: state_d = S_RD_Y;
      S_RD_Y: begin
        {w_d, h_d}                = table_data[15:8];
        {vflip_d, hflip_d, pal_d} = table_data[6:0];
        state_d = table_data[15:8] == 8'hFF ? S_END : S_RD_X;
      end
      S_RD_X: begin
        y_d     = table_data[8:0];
        state_d = S_RD_CODE;
      end
      S_RD_CODE: begin
        x_d     = table_data[8:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        code_d  = table_data;
        c_d     = 4'd0;
        ny_d    = vflip_q ? h_q - diff[7:4] : diff[7:4];
        vsub_d  = diff[3:0] ^ {4{vflip_q}};
        state_d = hit ? S_EMIT : S_NEXT;
      end
      S_EMIT: begin
        if (!dr_valid_q) dr_valid_d = 1'b1;
        else if (dr_ready) begin
          dr_valid_d = 1'b0;
          if (c_q == w_q) state_d = S_NEXT;
          else c_d = c_q + 4'd1;
        end
      end
      S_NEXT: begin
        state_d = obj_q == 8'(LAST_OBJ) ? S_END : S_RD_ATTR;
        obj_d   = obj_q == 8'(LAST_OBJ) ? obj_q : obj_q + 8'd1;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A start pulse always wins: it aborts any scan in flight.
    if (start) begin
      state_d    = S_RD_ATTR;
      obj_d      = 8'd0;
      vline_d    = vrender;
      dr_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      obj_q      <= '0;
      vline_q    <= '0;
      y_q        <= '0;
      x_q        <= '0;
      code_q     <= '0;
      w_q        <= '0;
      h_q        <= '0;
      ny_q       <= '0;
      vsub_q     <= '0;
      c_q        <= '0;
      vflip_q    <= 1'b0;
      hflip_q    <= 1'b0;
      pal_q      <= '0;
      dr_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      obj_q      <= obj_d;
      vline_q    <= vline_d;
      y_q        <= y_d;
      x_q        <= x_d;
      code_q     <= code_d;
      w_q        <= w_d;
      h_q        <= h_d;
      ny_q       <= ny_d;
      vsub_q     <= vsub_d;
      c_q        <= c_d;
      vflip_q    <= vflip_d;
      hflip_q    <= hflip_d;
      pal_q      <= pal_d;
      dr_valid_q <= dr_valid_d;
    end
  end
endmodule

// File: tb/tb_jtcps1_obj_scan.sv
// tb_jtcps1_obj_scan: table-driven vectors plus directed multi-cycle sequences for the OBJ scanner.
module tb_jtcps1_obj_scan;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dr_ready = 1'b0;
  logic [8:0]  vrender = '0;
  logic [9:0]  table_addr;
  logic [15:0] table_data = '0;
  logic        dr_valid, dr_hflip, busy, line_done;
  logic [15:0] dr_code;
  logic [8:0]  dr_hpos;
  logic [3:0]  dr_vsub;
  logic [4:0]  dr_pal;
  logic [15:0] mem [0:1023];

  typedef struct packed {
    logic [15:0] code;
    logic [8:0]  hpos;
    logic [3:0]  vsub;
    logic [4:0]  pal;
    logic        hf;
  } req_t;
  typedef struct {
    logic [15:0] x, y, code, attr;
    logic [8:0]  vr;
    int          n;
    req_t        r0, r1;
  } vec_t;

  req_t       got[$];
  logic [9:0] addrs[$];
  int         ld_cnt = 0;
  int         n_cmp = 0, n_bad = 0;
  req_t       cur_r;
  vec_t       vecs[10];

  always #5 clk = ~clk;
  always @(posedge clk) table_data <= mem[table_addr];
  assign cur_r = {dr_code, dr_hpos, dr_vsub, dr_pal, dr_hflip};

  jtcps1_obj_scan #(.LAST_OBJ(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vrender(vrender),
    .table_addr(table_addr), .table_data(table_data),
    .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_code(dr_code), .dr_hpos(dr_hpos),
    .dr_vsub(dr_vsub), .dr_pal(dr_pal), .dr_hflip(dr_hflip),
    .busy(busy), .line_done(line_done)
  );

  // Inputs change at posedge+1, so the negedge view is what the next edge will act on.
  always @(negedge clk) if (rst_n) begin
    if (dr_valid && dr_ready && !start) got.push_back(cur_r);
    if (line_done) ld_cnt++;
    addrs.push_back(table_addr);
  end

  function automatic req_t rq(logic [15:0] c, logic [8:0] h, logic [3:0] v, logic [4:0] p, logic f);
    return {c, h, v, p, f};
  endfunction

  function automatic logic [9:0] max_from(int b);
    logic [9:0] m = '0;
    for (int i = b; i < addrs.size(); i++) if (addrs[i] > m) m = addrs[i];
    return m;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] x, y, code, attr);
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = x; mem[1] = y; mem[2] = code; mem[3] = attr; mem[7] = 16'hFF00;
  endtask

  task automatic pulse_start(input logic [8:0] vr);
    @(posedge clk); #1;
    vrender = vr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ld(input int target, input string nm);
    int k = 0;
    while (ld_cnt < target && k < 5000) begin
      @(posedge clk);
      k++;
    end
    check({nm, " line_done timeout"}, ld_cnt >= target, 1);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!dr_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({nm, " dr_valid timeout"}, dr_valid, 1);
  endtask

  initial begin
    int gb, ab, lb, bad, k;
    req_t snap;
    vecs[0] = '{16'h040, 16'h020, 16'h1234, 16'h0005, 9'h025, 1, rq(16'h1234, 9'h040, 4'h5, 5'h05, 0), '0};
    vecs[1] = '{16'h040, 16'h020, 16'h1234, 16'h0045, 9'h025, 1, rq(16'h1234, 9'h040, 4'hA, 5'h05, 0), '0};
    vecs[2] = '{16'h040, 16'h020, 16'h1234, 16'h0005, 9'h030, 0, '0, '0};
    vecs[3] = '{16'h100, 16'h020, 16'h123F, 16'h1100, 9'h035, 2, rq(16'h124F, 9'h100, 4'h5, 5'h00, 0),
                rq(16'h1240, 9'h110, 4'h5, 5'h00, 0)};
    vecs[4] = '{16'h100, 16'h020, 16'h123F, 16'h1120, 9'h035, 2, rq(16'h1240, 9'h100, 4'h5, 5'h00, 1),
                rq(16'h124F, 9'h110, 4'h5, 5'h00, 1)};
    vecs[5] = '{16'h040, 16'h1F8, 16'h1234, 16'h0000, 9'h002, 1, rq(16'h1234, 9'h040, 4'hA, 5'h00, 0), '0};
    vecs[6] = '{16'h1F8, 16'h020, 16'h1234, 16'h1000, 9'h025, 2, rq(16'h1234, 9'h1F8, 4'h5, 5'h00, 0),
                rq(16'h1235, 9'h008, 4'h5, 5'h00, 0)};
    vecs[7] = '{16'h080, 16'h020, 16'h5670, 16'h0142, 9'h025, 1, rq(16'h5680, 9'h080, 4'hA, 5'h02, 0), '0};
    vecs[8] = '{16'h000, 16'h000, 16'h0001, 16'h0003, 9'h003, 1, rq(16'h0001, 9'h000, 4'h3, 5'h03, 0), '0};
    vecs[9] = '{16'h040, 16'h020, 16'h1234, 16'h0000, 9'h01F, 0, '0, '0};
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {dr_valid, busy, line_done, table_addr, cur_r}, '0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      load(vecs[v].x, vecs[v].y, vecs[v].code, vecs[v].attr);
      gb = got.size(); ab = addrs.size(); lb = ld_cnt;
      dr_ready = 1'b1;
      pulse_start(vecs[v].vr);
      wait_ld(lb + 1, $sformatf("v%0d", v));
      repeat (3) @(posedge clk);
      check($sformatf("v%0d nreq", v), got.size() - gb, vecs[v].n);
      for (int j = 0; j < vecs[v].n; j++)
        check($sformatf("v%0d req%0d", v, j), got[gb + j], j == 0 ? vecs[v].r0 : vecs[v].r1);
      check($sformatf("v%0d max addr", v), max_from(ab), 10'd7);
      check($sformatf("v%0d line_done count", v), ld_cnt - lb, 1);
      check($sformatf("v%0d busy after", v), busy, 0);
    end

    // Backpressure: request must hold steady while dr_ready is low.
    load(16'h100, 16'h020, 16'h123F, 16'h1100);
    gb = got.size(); lb = ld_cnt;
    dr_ready = 1'b0;
    pulse_start(9'h035);
    wait_valid("hold");
    snap = cur_r;
    check("hold first req", snap, rq(16'h124F, 9'h100, 4'h5, 5'h00, 0));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!dr_valid || cur_r !== snap) bad++;
    end
    check("hold stable cycles bad", bad, 0);
    check("hold no transfer", got.size() - gb, 0);
    @(posedge clk); #1;
    dr_ready = 1'b1;
    wait_ld(lb + 1, "hold");
    repeat (2) @(posedge clk);
    check("hold nreq", got.size() - gb, 2);
    check("hold second req", got[gb + 1], rq(16'h1240, 9'h110, 4'h5, 5'h00, 0));

    // Abort mid-EMIT with dr_ready high on the start cycle.
    gb = got.size(); lb = ld_cnt;
    dr_ready = 1'b0;
    pulse_start(9'h035);
    wait_valid("abort");
    @(posedge clk); #1;
    start = 1'b1; dr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort valid drop", dr_valid, 0);
    check("abort restart addr", table_addr, 10'd3);
    check("abort busy", busy, 1);
    wait_ld(lb + 1, "abort");
    repeat (3) @(posedge clk);
    check("abort line_done count", ld_cnt - lb, 1);
    check("abort nreq", got.size() - gb, 2);
    check("abort first req", got[gb], rq(16'h124F, 9'h100, 4'h5, 5'h00, 0));

    // Start coincident with the END cycle.
    load(16'h040, 16'h020, 16'h1234, 16'h0005);
    lb = ld_cnt;
    pulse_start(9'h030);
    k = 0;
    while (!line_done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("end-start seen line_done", line_done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("end-start busy", busy, 1);
    check("end-start addr", table_addr, 10'd3);
    wait_ld(lb + 2, "end-start");
    repeat (3) @(posedge clk);
    check("end-start line_done count", ld_cnt - lb, 2);

    // No end marker: scan runs through LAST_OBJ.
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    gb = got.size(); ab = addrs.size(); lb = ld_cnt;
    pulse_start(9'h100);
    wait_ld(lb + 1, "last");
    repeat (3) @(posedge clk);
    check("last nreq", got.size() - gb, 0);
    check("last max addr", max_from(ab), 10'd1023);
    check("last line_done count", ld_cnt - lb, 1);

    // Asynchronous reset while a request is pending.
    load(16'h100, 16'h020, 16'h123F, 16'h1100);
    dr_ready = 1'b0;
    pulse_start(9'h035);
    wait_valid("rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {dr_valid, busy, line_done, table_addr, cur_r}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/jtcps1_obj_scan.md
Name: jtcps1_obj_scan

Overview:
Line-based object scanner. It reads the OBJ table buffer that the OBJ DMA fills, over that buffer's read port (table_addr/table_data). For each scanline it walks the table entries, finds the objects that intersect the line, and expands multi-tile blocks into one draw request per tile. Requests go to the object line-buffer renderer over a valid/ready handshake.

Parameters:
LAST_OBJ, 255, index of the last table entry scanned when no end marker is found (entries 0..LAST_OBJ).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin scanning for line vrender
vrender  in  9  scanline to evaluate; sampled on start
table_addr  out  10  table word address: {obj[7:0], word[1:0]}; word 0=X, 1=Y, 2=code, 3=attr
table_data  in  16  table word; valid one clock after table_addr
dr_valid  out  1  draw request valid
dr_ready  in  1  renderer accepts the request
dr_code  out  16  tile code
dr_hpos  out  9  tile left x, mod 512
dr_vsub  out  4  row inside the tile, flip already applied
dr_pal  out  5  palette
dr_hflip  out  1  mirror tile horizontally
busy  out  1  scan in progress
line_done  out  1  one-cycle pulse when the scan ends

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; state IDLE; obj counter 0.
- Table read rule: address driven in cycle n, table_data captured in cycle n+1.
- IDLE: on start, latch vrender, obj=0, busy<=1, go to RD_ATTR.
- Per-object field reads, in order:
  - RD_ATTR: read word 3. If attr[15:8]==8'hFF, go to END; no further table reads.
  - RD_Y: read word 1.
  - RD_X: read word 0.
  - RD_CODE: read word 2.
- Attribute fields: w=attr[15:12] (tiles wide - 1), h=attr[11:8] (tiles high - 1), vflip=attr[6], hflip=attr[5], pal=attr[4:0].
- CHECK:
  - diff = (vline - Y[8:0]) mod 512 (9 bit); trow = diff[8:4].
  - Hit when trow <= {1'b0,h}; otherwise go to NEXT.
  - ny = vflip ? h - trow : trow.
  - dr_vsub = diff[3:0] ^ {4{vflip}}.
  - Column counter c = 0; go to EMIT.
- EMIT, per column c:
  - nx = hflip ? w - c : c.
  - dr_code = {code[15:4],4'b0} + ((code[3:0] + nx) & 4'hF) + 16*ny, 16-bit wrap.
  - dr_hpos = X[8:0] + 16*c, mod 512.
  - dr_pal = pal; dr_hflip = hflip.
  - Columns are emitted left to right.
- Handshake:
  - dr_valid is asserted with all fields stable.
  - A transfer occurs on any cycle with dr_valid & dr_ready.
  - dr_valid and all fields are held while dr_ready is low.
  - After the transfer: if c==w, go to NEXT; else c+1 and the next request is valid on the following cycle. Throughput is at most 1 request per 2 cycles.
- NEXT: if obj==LAST_OBJ, go to END; else obj+1, go to RD_ATTR.
- END: line_done=1 for one cycle, busy<=0, dr_valid<=0, return to IDLE.
- start while busy: abort the current scan. dr_valid drops the next cycle, with no transfer counted for that cycle even if dr_ready is high. Relatch vrender and restart at obj 0. No line_done for the aborted scan.
- start coincident with the END cycle: line_done still pulses, and the new scan begins.
- Entries with X==0 or Y==0 are not special; only the FF attribute marker terminates a scan.

Test Plan:
- Entry0 X=0x040 Y=0x020 code=0x1234 attr=0x0005, entry1 attr=0xFF00, vrender=0x025 -> one request: code 1234, hpos 040, vsub 5, pal 05, hflip 0; then line_done. table_addr never exceeds 7.
- Same entry with attr=0x0045 (vflip) -> vsub A. Same entry with vrender=0x030 -> no request, line_done.
- 2x2 block, attr=0x1100, code=0x123F, X=0x100, Y=0x020, vrender=0x035 -> two requests: (124F, 100, vsub 5) then (1240, 110, vsub 5).
- Same block with attr=0x1120 (hflip) -> (1240, 100) then (124F, 110), both with dr_hflip=1.
- Y=0x1F8, vrender=0x002, 1x1 -> hit, vsub A. X=0x1F8, w=1 -> second tile hpos 0x008.
- dr_ready held low 10 cycles -> dr_valid and fields constant. Assert start mid-scan -> restart from table_addr 3, no line_done for the aborted scan. Pulse rst_n low mid-EMIT -> all outputs 0 immediately.
